// File: rtl/img_byte_unpacker_if.sv
// Word-in / byte-out bus between the image buffer, the unpacker and the pixel consumer.
interface img_byte_unpacker_if #(
    parameter int LEN_BITS = 10
) ();
    logic [31:0]         in_data;
    logic                in_valid;
    logic                upstream_stall;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_last;
    logic                downstream_stall;
    logic [LEN_BITS-1:0] frame_len;
    logic                frame_done;

    // Producer/consumer side: feeds words and applies backpressure on bytes.
    modport master (
        output in_data, in_valid, downstream_stall,
        input  upstream_stall, out_data, out_valid, out_last, frame_len, frame_done
    );

    // Unpacker side.
    modport slave (
        input  in_data, in_valid, downstream_stall,
        output upstream_stall, out_data, out_valid, out_last, frame_len, frame_done
    );
endinterface

// File: rtl/img_byte_unpacker.sv
// Splits a header-prefixed 32-bit word stream into little-endian pixel bytes.
// The header word carries the frame byte length N; padding bytes in the final
// word are dropped. All outputs come from registers or state decode.
module img_byte_unpacker #(
    parameter int LEN_BITS = 10
) (
    input  logic              clock,
    input  logic              reset,
    img_byte_unpacker_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;

    localparam logic [LEN_BITS-1:0] LEN_ZERO = '0;
    localparam logic [LEN_BITS-1:0] LEN_ONE  = {{(LEN_BITS-1){1'b0}}, 1'b1};

    logic [1:0]          state;
    logic [31:0]         word_q;
    logic [1:0]          byte_idx;
    logic [LEN_BITS-1:0] bytes_left;
    logic [LEN_BITS-1:0] frame_len_q;
    logic [7:0]          out_data_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                frame_done_q;

    logic [LEN_BITS-1:0] hdr_len;
    logic [LEN_BITS-1:0] left_after;
    logic [1:0]          next_idx;
    logic                word_end;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

    // Header length, post-transfer count and end-of-word detection for the held word.
    always_comb begin
        hdr_len    = bus.in_data[LEN_BITS-1:0];
        left_after = bytes_left - LEN_ONE;
        next_idx   = byte_idx + 2'd1;
        word_end   = (byte_idx == 2'd3) || (bytes_left == LEN_ONE);
    end

    assign bus.upstream_stall = (state == S_EMIT);
    assign bus.out_data       = out_data_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_last       = out_last_q;
    assign bus.frame_len      = frame_len_q;
    assign bus.frame_done     = frame_done_q;

    // Frame sequencing: header -> (load word -> emit its bytes)* -> done pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            word_q       <= '0;
            byte_idx     <= '0;
            bytes_left   <= '0;
            frame_len_q  <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        frame_len_q <= hdr_len;
                        bytes_left  <= hdr_len;
                        if (hdr_len == LEN_ZERO) begin
                            frame_done_q <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        word_q      <= bus.in_data;
                        byte_idx    <= 2'd0;
                        out_data_q  <= bus.in_data[7:0];
                        out_valid_q <= 1'b1;
                        out_last_q  <= (bytes_left == LEN_ONE);
                        state       <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (!bus.downstream_stall) begin
                        bytes_left <= left_after;
                        if (word_end) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            if (left_after == LEN_ZERO) begin
                                state        <= S_IDLE;
                                frame_done_q <= 1'b1;
                            end else begin
                                state <= S_LOAD;
                            end
                        end else begin
                            byte_idx   <= next_idx;
                            out_data_q <= pick_byte(word_q, next_idx);
                            out_last_q <= (left_after == LEN_ONE);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_img_byte_unpacker.sv
// Bench for img_byte_unpacker: directed frames with literal byte expectations
// plus randomized frames checked every cycle against a frame-level model.
module tb_img_byte_unpacker;

    localparam int LEN = 10;

    typedef struct packed {
        logic [7:0]     b;
        logic           l;
        logic [LEN-1:0] len;
    } ent_t;

    logic clock;
    logic reset;

    img_byte_unpacker_if #(.LEN_BITS(LEN)) bus ();

    img_byte_unpacker #(.LEN_BITS(LEN)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_pass  = 0;
    int n_total = 0;

    // Model state: expected bytes in output order, frame bookkeeping.
    ent_t           q[$];
    ent_t           pin_q[$];
    int             words_left = 0;
    int             bytes_rem  = 0;
    logic [LEN-1:0] len_exp    = '0;
    bit             done_exp   = 1'b0;
    bit             done_next  = 1'b0;
    int             stall_mode = 0;
    int             scnt       = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_accept(input logic [31:0] w);
        ent_t e;
        int   k;
        if (words_left == 0) begin
            len_exp = w[LEN-1:0];
            if (w[LEN-1:0] == '0) begin
                done_next = 1'b1;
            end else begin
                bytes_rem  = int'(w[LEN-1:0]);
                words_left = (bytes_rem + 3) / 4;
            end
        end else begin
            k = (bytes_rem < 4) ? bytes_rem : 4;
            for (int i = 0; i < k; i++) begin
                e.b   = w[8*i +: 8];
                e.l   = (bytes_rem - i == 1);
                e.len = len_exp;
                q.push_back(e);
            end
            bytes_rem  -= k;
            words_left -= 1;
        end
    endtask

    // Compare process: outputs checked on every falling edge.
    initial begin
        ent_t e;
        ent_t p;
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
                chk("rst_out_data", 32'(bus.out_data), 32'(0));
                chk("rst_out_last", 32'(bus.out_last), 32'(0));
                chk("rst_frame_done", 32'(bus.frame_done), 32'(0));
                chk("rst_frame_len", 32'(bus.frame_len), 32'(0));
                chk("rst_upstream_stall", 32'(bus.upstream_stall), 32'(0));
                q.delete();
                words_left = 0;
                bytes_rem  = 0;
                len_exp    = '0;
                done_exp   = 1'b0;
            end else begin
                chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
                chk("upstream_stall", 32'(bus.upstream_stall), 32'(q.size() != 0));
                chk("frame_done", 32'(bus.frame_done), 32'(done_exp));
                chk("frame_len", 32'(bus.frame_len), 32'(len_exp));
                if (q.size() != 0) begin
                    chk("out_data", 32'(bus.out_data), 32'(q[0].b));
                    chk("out_last", 32'(bus.out_last), 32'(q[0].l));
                end
                done_next = 1'b0;
                if (q.size() != 0 && !bus.downstream_stall) begin
                    e = q.pop_front();
                    if (pin_q.size() != 0) begin
                        p = pin_q.pop_front();
                        chk("pin_data", 32'(bus.out_data), 32'(p.b));
                        chk("pin_last", 32'(bus.out_last), 32'(p.l));
                        chk("pin_len", 32'(bus.frame_len), 32'(p.len));
                    end
                    if (e.l) done_next = 1'b1;
                end
                if (bus.in_valid && !bus.upstream_stall) model_accept(bus.in_data);
                done_exp = done_next;
            end
        end
    end

    // Consumer backpressure: off, random, or a 3-cycle hold on byte 0x02.
    initial begin
        bus.downstream_stall = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (stall_mode)
                1: bus.downstream_stall = ($urandom_range(0, 3) == 0);
                2: begin
                    if (bus.out_valid && bus.out_data == 8'h02 && scnt < 3) begin
                        bus.downstream_stall = 1'b1;
                        scnt++;
                    end else begin
                        bus.downstream_stall = 1'b0;
                    end
                end
                default: bus.downstream_stall = 1'b0;
            endcase
        end
    end

    task automatic pin(input logic [7:0] b, input logic l, input logic [LEN-1:0] len);
        ent_t e;
        e.b = b; e.l = l; e.len = len;
        pin_q.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] w);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        while (!acc) begin
            @(negedge clock);
            acc = !bus.upstream_stall;
            @(posedge clock);
            #1;
            n++;
            if (n > 2000) begin
                $display("FAIL word_accept_timeout: got no accept expected accept of %08h", w);
                $fatal(1, "word accept timeout");
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
    endtask

    task automatic gap(input int maxc);
        repeat ($urandom_range(0, maxc)) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_frame(input int n, input bit junk_hi);
        logic [31:0] hdr;
        hdr = 32'(n);
        if (junk_hi) hdr = ($urandom & ~32'h3FF) | 32'(n);
        send_word(hdr);
        for (int i = 0; i < (n + 3) / 4; i++) begin
            gap(2);
            send_word($urandom);
        end
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (q.size() != 0 || pin_q.size() != 0 || words_left != 0) begin
            @(posedge clock);
            #1;
            n++;
            if (n > 5000) begin
                $display("FAIL drain_timeout: got %0d bytes pending expected 0", q.size() + pin_q.size());
                $fatal(1, "drain timeout");
            end
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Two full words, no stall.
        pin(8'h11, 0, 8); pin(8'h22, 0, 8); pin(8'h33, 0, 8); pin(8'h44, 0, 8);
        pin(8'h55, 0, 8); pin(8'h66, 0, 8); pin(8'h77, 0, 8); pin(8'h88, 1, 8);
        send_word(32'd8);
        send_word(32'h44332211);
        send_word(32'h88776655);
        drain();

        // Partial final word: padding bytes must not appear.
        pin(8'hAA, 0, 5); pin(8'hBB, 0, 5); pin(8'hCC, 0, 5); pin(8'hDD, 0, 5); pin(8'hEE, 1, 5);
        send_word(32'd5);
        send_word(32'hDDCCBBAA);
        send_word(32'h000000EE);
        drain();

        // Empty frame, then a header with bits above the length field set.
        send_word(32'd0);
        pin(8'hA0, 0, 3); pin(8'hB0, 0, 3); pin(8'hC0, 1, 3);
        send_word(32'h00000403);
        send_word(32'h77C0B0A0);
        drain();

        // Consumer holds byte 0x02 for three cycles.
        stall_mode = 2;
        pin(8'h01, 0, 4); pin(8'h02, 0, 4); pin(8'h03, 0, 4); pin(8'h04, 1, 4);
        send_word(32'd4);
        send_word(32'h04030201);
        drain();

        // Reset while the second byte of a frame is on the output.
        stall_mode = 0;
        send_word(32'd8);
        send_word(32'h44332211);
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (n > 100) begin
                $display("FAIL byte2_wait_timeout: got %02h expected 22", bus.out_data);
                $fatal(1, "byte 2 wait timeout");
            end
        end while (!(bus.out_valid && bus.out_data == 8'h22));
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        pin(8'hAB, 1, 1);
        send_word(32'd1);
        send_word(32'h000000AB);
        drain();

        // Randomized frames with random backpressure and input gaps.
        stall_mode = 1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 9) == 0) send_frame(0, $urandom_range(0, 1) == 1);
            else send_frame($urandom_range(1, 37), $urandom_range(0, 1) == 1);
            gap(3);
        end
        send_frame(1023, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/img_byte_unpacker.md
IMG_BYTE_UNPACKER -- requirements
Module: img_byte_unpacker

Interface
REQ-001 SHALL have parameter LEN_BITS, default 10, meaning the width of the frame byte-length field taken from the header word.
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port in_data  input  32  the word stream from the image buffer: one header word (frame byte length N), then ceil(N/4) data words.
REQ-005 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port upstream_stall  output  1  high = word not accepted; upstream holds in_data/in_valid.
REQ-007 SHALL have port out_data  output  8  current pixel byte.
REQ-008 SHALL have port out_valid  output  1  out_data valid.
REQ-009 SHALL have port out_last  output  1  out_data is byte N-1 of the frame.
REQ-010 SHALL have port downstream_stall  input  1  high = consumer not taking out_data this cycle.
REQ-011 SHALL have port frame_len  output  LEN_BITS  byte length N of the current/most recent frame.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-013 SHALL implement states IDLE (await header), LOAD (await data word), EMIT (output bytes of held word).
REQ-014 SHALL accept a word when in_valid=1 and upstream_stall=0; upstream_stall=1 exactly in EMIT, 0 in IDLE and LOAD.
REQ-015 SHALL, on header accept in IDLE, latch N=in_data[LEN_BITS-1:0] into frame_len and bytes_left; bits above LEN_BITS ignored.
REQ-016 SHALL, on header with N!=0, go IDLE->LOAD; with N=0, stay IDLE, emit no bytes, pulse frame_done next cycle.
REQ-017 SHALL, on word accept in LOAD, hold the word, go to EMIT, present byte 0 (in_data[7:0]) with out_valid=1 on the following cycle (1-cycle latency).
REQ-018 SHALL emit bytes little-endian: byte k = word[8k+7:8k], k=0..3.
REQ-019 SHALL, in EMIT, transfer a byte on each cycle with downstream_stall=0; present the next byte the following cycle; decrement bytes_left per transfer.
REQ-020 SHALL hold out_data, out_valid, out_last unchanged while downstream_stall=1.
REQ-021 SHALL emit only bytes_left bytes from the final word when N mod 4 != 0 (padding bytes discarded, never output).
REQ-022 SHALL assert out_last with the byte transferred when bytes_left=1.
REQ-023 SHALL, after the last byte of a word transfers: go EMIT->LOAD if bytes_left>0 after the transfer, else EMIT->IDLE with frame_done=1 for the next single cycle.
REQ-024 SHALL keep out_valid=0 in IDLE and LOAD; in_valid while in EMIT has no effect.
REQ-025 SHALL drive all outputs from registers or decode of state registers only; no combinational path from in_* to out_* or downstream_stall to upstream_stall.
REQ-026 SHALL sustain one byte per cycle inside a word; one idle cycle (LOAD) per word boundary is permitted.

Reset
REQ-027 SHALL, while reset=0, asynchronously force state=IDLE, out_data=0, out_valid=0, out_last=0, frame_done=0, frame_len=0, bytes_left=0, held word=0, upstream_stall=0.
REQ-028 SHALL, on reset asserted mid-frame, discard the partial frame; the next accepted word after release is treated as a header.

Verification
REQ-029 SHALL pass: header 8, words 0x44332211, 0x88776655, no stall -> bytes 11,22,33,44,55,66,77,88, out_last on 88, frame_done 1 cycle after.
REQ-030 SHALL pass: header 5, words 0xDDCCBBAA, 0x000000EE -> bytes AA,BB,CC,DD,EE only, out_last on EE, frame_len=5.
REQ-031 SHALL pass: header 0 -> no out_valid, frame_done pulse, next word treated as header.
REQ-032 SHALL pass: header 4, word 0x04030201, downstream_stall=1 for 3 cycles on byte 02 -> 02 held stable 3 cycles, order 01,02,03,04, upstream_stall=1 throughout EMIT.
REQ-033 SHALL pass: reset=0 during byte 2 of a header-8 frame -> outputs cleared immediately; after release, header 1 + word 0x000000AB -> single byte AB with out_last.
REQ-034 SHALL pass: header 0x00000403 with LEN_BITS=10 -> N=3, three bytes emitted from one word.
